// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide unit:
// ALU control words, ALUOp values, funct codes and the MDU sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

  // HI/LO moves sit at 0100xx and multiply/divide at 0110xx.
  function automatic logic is_mdu_funct(input logic [5:0] funct);
    return (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or one restoring-subtract
// step per cycle while run is high, for exactly WIDTH steps after start.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand_b;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  // Both operations end with the high half in acc and the low half
  // (product low word or quotient) in shreg.
  always_comb begin
    mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, operand_b} : '0);
    div_shift = {acc, shreg[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand_b};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_next   = div_trial[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next   = div_shift[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next   = mul_sum[WIDTH:1];
      shreg_next = {mul_sum[0], shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      shreg     <= '0;
      operand_b <= '0;
      cnt       <= '0;
    end else if (start) begin
      acc       <= '0;
      shreg     <= op_a;
      operand_b <= op_b;
      cnt       <= CNT_W'(WIDTH - 1);
    end else if (run) begin
      acc   <= acc_next;
      shreg <= shreg_next;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign last   = (cnt == '0);
  assign acc_hi = acc;
  assign acc_lo = shreg;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an attached iterative multiply/divide unit and
// HI/LO registers; raises stall while an MDU instruction meets a busy unit.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CTL_W   = 4,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         func_code,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic               stall,
  output logic               busy,
  output logic [WIDTH-1:0]   hilo_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  mdu_state_e state, state_next;

  logic [3:0]         ctl;
  logic               funct_op;
  logic               issue;
  logic               start_mul;
  logic               start_div;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               op_div;
  logic               res_neg;
  logic               rem_neg;
  logic               div0;
  logic               run;
  logic               iter_div;
  logic               fix_wr;
  logic               last;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    ctl = CTL_NOP;
    if (alu_op == ALUOP_W'(ALUOP_ADD)) begin
      ctl = CTL_ADD;
    end else if (alu_op == ALUOP_W'(ALUOP_SUB)) begin
      ctl = CTL_SUB;
    end else if (alu_op == ALUOP_W'(ALUOP_FUNCT)) begin
      case (func_code)
        FN_ADD:  ctl = CTL_ADD;
        FN_SUB:  ctl = CTL_SUB;
        FN_AND:  ctl = CTL_AND;
        FN_OR:   ctl = CTL_OR;
        FN_NOR:  ctl = CTL_NOR;
        FN_SLT:  ctl = CTL_SLT;
        default: ctl = CTL_NOP;
      endcase
    end
  end

  assign alu_ctl   = CTL_W'(ctl);
  assign funct_op  = (alu_op == ALUOP_W'(ALUOP_FUNCT));
  assign stall     = valid & funct_op & is_mdu_funct(func_code) & busy;
  assign issue     = valid & ~stall & funct_op;
  assign start_mul = issue & ((func_code == FN_MULT) | (func_code == FN_MULTU));
  assign start_div = issue & ((func_code == FN_DIV)  | (func_code == FN_DIVU));

  // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
  assign signed_op = (func_code == FN_MULT) | (func_code == FN_DIV);
  assign a_neg     = signed_op & rs_val[WIDTH-1];
  assign b_neg     = signed_op & rt_val[WIDTH-1];
  assign a_mag     = a_neg ? -rs_val : rs_val;
  assign b_mag     = b_neg ? -rt_val : rt_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      div0    <= 1'b0;
    end else if (start_mul | start_div) begin
      op_div  <= start_div;
      res_neg <= a_neg ^ b_neg;
      rem_neg <= a_neg;
      div0    <= (rt_val == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_next = ST_MUL;
        else if (start_div) state_next = ST_DIV;
      end
      ST_MUL:  if (last) state_next = ST_FIX;
      ST_DIV:  if (last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    run      = (state == ST_MUL) || (state == ST_DIV);
    iter_div = (state == ST_DIV);
    fix_wr   = (state == ST_FIX);
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_mul | start_div),
    .run    (run),
    .is_div (iter_div),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .last   (last),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Divide by zero leaves the dividend in the remainder; the quotient is forced to all ones.
  assign prod_fix = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = div0 ? '1 : (res_neg ? -acc_lo : acc_lo);
  assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      if (op_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (issue && func_code == FN_MTHI) begin
      hi <= rs_val;
    end else if (issue && func_code == FN_MTLO) begin
      lo <= rs_val;
    end
  end

  always_comb begin
    hilo_result = '0;
    if (funct_op && func_code == FN_MFHI) hilo_result = hi;
    else if (funct_op && func_code == FN_MFLO) hilo_result = lo;
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Randomized self-checking bench for alu_ctrl_mdu at WIDTH=32 and WIDTH=8,
// compared against an arithmetic reference model of decode and MDU results.
module tb_alu_ctrl_mdu;

  localparam int W32 = 32;
  localparam int W8  = 8;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        valid;
  logic [1:0]  alu_op;
  logic [5:0]  func_code;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_ctl;
  logic        stall, busy;
  logic [31:0] hilo_result, hi, lo;

  logic        valid8;
  logic [1:0]  alu_op8;
  logic [5:0]  func_code8;
  logic [7:0]  rs_val8, rt_val8;
  logic [3:0]  alu_ctl8;
  logic        stall8, busy8;
  logic [7:0]  hilo_result8, hi8, lo8;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.WIDTH(W32), .CTL_W(4), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .alu_op(alu_op), .func_code(func_code),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctl(alu_ctl), .stall(stall), .busy(busy),
    .hilo_result(hilo_result), .hi(hi), .lo(lo)
  );

  alu_ctrl_mdu #(.WIDTH(W8), .CTL_W(4), .ALUOP_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid(valid8), .alu_op(alu_op8), .func_code(func_code8),
    .rs_val(rs_val8), .rt_val(rt_val8), .alu_ctl(alu_ctl8), .stall(stall8), .busy(busy8),
    .hilo_result(hilo_result8), .hi(hi8), .lo(lo8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b);
    valid = v; alu_op = op; func_code = f; rs_val = a; rt_val = b;
  endtask

  task automatic applyStimulus8(input logic v, input logic [1:0] op, input logic [5:0] f,
                                input logic [7:0] a, input logic [7:0] b);
    valid8 = v; alu_op8 = op; func_code8 = f; rs_val8 = a; rt_val8 = b;
  endtask

  function automatic logic [3:0] refCtl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b1111;
    endcase
  endfunction

  // Returns {HI, LO}, each zero-extended to 64 bits, for a w-bit MDU op.
  function automatic logic [127:0] refMdu(input logic [5:0] f, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [63:0] mask, rhi, rlo, up, sp64;
    longint sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    rhi = '0;
    rlo = '0;
    case (f)
      F_MULT: begin
        sp = sa * sb;
        sp64 = 64'(sp);
        rhi = (sp64 >> w) & mask;
        rlo = sp64 & mask;
      end
      F_MULTU: begin
        up = a * b;
        rhi = (up >> w) & mask;
        rlo = up & mask;
      end
      F_DIV: begin
        if (b == 64'd0) begin
          rhi = a; rlo = mask;
        end else begin
          rlo = 64'(sa / sb) & mask;
          rhi = 64'(sa % sb) & mask;
        end
      end
      default: begin
        if (b == 64'd0) begin
          rhi = a; rlo = mask;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
    return {rhi, rlo};
  endfunction

  task automatic runOp32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [127:0] expv;
    int n;
    expv = refMdu(f, {32'd0, a}, {32'd0, b}, W32);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, f, a, b);
    @(negedge clk);
    n = 0;
    // Unrelated non-MDU traffic while busy must neither stall nor disturb the op.
    while (busy && n < 200) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom);
      #1;
      if (stall) checkOutput("nonmdu_stall", {63'd0, stall}, 64'd0);
      n++;
      @(negedge clk);
    end
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    checkOutput("busy_cycles", 64'(n), 64'(W32 + 1));
    checkOutput("hi", {32'd0, hi}, expv[127:64]);
    checkOutput("lo", {32'd0, lo}, expv[63:0]);
  endtask

  task automatic runOp8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [127:0] expv;
    int n;
    expv = refMdu(f, {56'd0, a}, {56'd0, b}, W8);
    @(negedge clk);
    applyStimulus8(1'b1, 2'b10, f, a, b);
    @(negedge clk);
    applyStimulus8(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles8", 64'(n), 64'(W8 + 1));
    checkOutput("hi8", {56'd0, hi8}, expv[127:64]);
    checkOutput("lo8", {56'd0, lo8}, expv[63:0]);
  endtask

  logic [5:0] decodeFuncts [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [5:0] mduOps [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  initial begin
    logic [127:0] expv;
    logic [31:0] a, b;
    logic [7:0] a8, b8;
    logic [1:0] op;
    logic [5:0] f;
    int n;

    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    applyStimulus8(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
    #12;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy8", {63'd0, busy8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] decode sweep");
    foreach (decodeFuncts[i]) begin
      applyStimulus(1'b0, 2'b10, decodeFuncts[i], 32'd0, 32'd0);
      #1;
      checkOutput("alu_ctl_funct", {60'd0, alu_ctl}, {60'd0, refCtl(2'b10, decodeFuncts[i])});
    end
    applyStimulus(1'b0, 2'b01, 6'b010100, 32'd0, 32'd0);
    #1;
    checkOutput("alu_ctl_sub", {60'd0, alu_ctl}, 64'h6);
    applyStimulus(1'b0, 2'b10, 6'b000000, 32'd0, 32'd0);
    #1;
    checkOutput("alu_ctl_nop", {60'd0, alu_ctl}, 64'hF);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 1) == 1) ? decodeFuncts[$urandom_range(0, 5)] : 6'($urandom);
      applyStimulus(1'b0, op, f, $urandom, $urandom);
      #1;
      checkOutput("alu_ctl_rand", {60'd0, alu_ctl}, {60'd0, refCtl(op, f)});
    end
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);

    $display("[TB] directed MDU ops");
    runOp32(F_MULT, 32'hFFFFFFFD, 32'd7);
    runOp32(F_MULTU, 32'hFFFFFFFF, 32'd2);
    runOp32(F_DIV, 32'hFFFFFFF9, 32'd2);
    runOp32(F_DIVU, 32'd100, 32'd7);
    runOp32(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    runOp32(F_DIVU, 32'h1234, 32'd0);
    runOp32(F_DIV, 32'hFFFF0000, 32'd0);

    $display("[TB] HI/LO moves");
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MTHI, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MTLO, 32'h3C3C0F0F, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    #1;
    checkOutput("mfhi", {32'd0, hilo_result}, 64'hA5A5A5A5);
    applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    checkOutput("mflo", {32'd0, hilo_result}, 64'h3C3C0F0F);
    applyStimulus(1'b1, 2'b10, 6'b100000, 32'd0, 32'd0);
    #1;
    checkOutput("hilo_unsel", {32'd0, hilo_result}, 64'd0);

    $display("[TB] reset during DIV");
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    checkOutput("busy_mid_div", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp32(F_MULT, 32'd12345, 32'hFFFFE57B);

    $display("[TB] MFLO hazard behind MULT");
    a = 32'h00ABCDEF;
    b = 32'hFFFFF000;
    expv = refMdu(F_MULT, {32'd0, a}, {32'd0, b}, W32);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MULT, a, b);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput("stall_cycles", 64'(n), 64'(W32 + 1));
    checkOutput("mflo_after_mult", {32'd0, hilo_result}, expv[63:0]);
    checkOutput("hi_after_mult", {32'd0, hi}, expv[127:64]);

    $display("[TB] ADD during busy");
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_DIVU, 32'd99999, 32'd13);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 6'b100000, 32'd1, 32'd2);
    #1;
    checkOutput("add_busy", {63'd0, busy}, 64'd1);
    checkOutput("add_stall", {63'd0, stall}, 64'd0);
    checkOutput("add_ctl", {60'd0, alu_ctl}, 64'h2);
    applyStimulus(1'b1, 2'b10, F_MULT, 32'd5, 32'd5);
    #1;
    checkOutput("mult_while_busy_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("divu_busy_done", {63'd0, busy}, 64'd0);
    checkOutput("divu_lo", {32'd0, lo}, 64'(99999 / 13));
    checkOutput("divu_hi", {32'd0, hi}, 64'(99999 % 13));

    $display("[TB] random MDU ops, width 32");
    for (int i = 0; i < 24; i++) begin
      f = mduOps[$urandom_range(0, 3)];
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runOp32(f, a, b);
    end

    $display("[TB] MDU ops, width 8");
    runOp8(F_MULT, 8'hFD, 8'd7);
    runOp8(F_DIV, 8'h80, 8'hFF);
    runOp8(F_DIVU, 8'h34, 8'd0);
    for (int i = 0; i < 16; i++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      runOp8(mduOps[$urandom_range(0, 3)], a8, b8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
